// File: rtl/fast_decrement_timer.sv
// Loadable one-shot countdown timer using a mask-and-XOR decrementer.
// Define FAST_DECREMENT_TIMER_CHECK_EN to add a sticky self-check (fail) of the decrementer.
module fast_decrement_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_vld,
  input  logic [W-1:0] start_cnt,
  output logic         start_rdy,
  input  logic         pause,
  input  logic         abort,
  output logic         busy,
  output logic [W-1:0] cnt,
  output logic         done,
  output logic         fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   dec_mask, dec_cnt;
  logic           zeros_below;
  logic           cnt_is_one;

  // Mask bit i is set while every bit below i is zero: covers the lowest 1 and all bits under it.
  always_comb begin
    zeros_below = 1'b1;
    dec_mask    = '0;
    for (int unsigned i = 0; i < W; i++) begin
      dec_mask[i] = zeros_below;
      zeros_below = zeros_below & ~cnt_q[i];
    end
  end

  assign dec_cnt    = cnt_q ^ dec_mask;
  assign cnt_is_one = (cnt_q == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_vld) begin
          cnt_d   = start_cnt;
          state_d = (start_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!pause) begin
          cnt_d = dec_cnt;
          if (cnt_is_one) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign start_rdy = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign cnt       = cnt_q;

`ifdef FAST_DECREMENT_TIMER_CHECK_EN
  logic         fail_q;
  logic         run_dec;
  logic [W-1:0] ref_cnt;

  assign run_dec = (state_q == RUN) && !abort && !pause;
  assign ref_cnt = cnt_q - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= 1'b0;
    end else if (run_dec && (dec_cnt != ref_cnt)) begin
      fail_q <= 1'b1;
    end
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_fast_decrement_timer.sv
// Directed bench for fast_decrement_timer: W=8 instance checked through an expected-trace queue,
// plus a W=32 instance for the width-scaling case.
module tb_fast_decrement_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_vld, pause, abort;
  logic [7:0]  start_cnt;
  logic        start_rdy, busy, done, fail;
  logic [7:0]  cnt;

  logic        start_vld32, pause32, abort32;
  logic [31:0] start_cnt32;
  logic        start_rdy32, busy32, done32, fail32;
  logic [31:0] cnt32;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  fast_decrement_timer #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_vld(start_vld), .start_cnt(start_cnt),
    .start_rdy(start_rdy), .pause(pause), .abort(abort), .busy(busy),
    .cnt(cnt), .done(done), .fail(fail)
  );

  fast_decrement_timer #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_vld(start_vld32), .start_cnt(start_cnt32),
    .start_rdy(start_rdy32), .pause(pause32), .abort(abort32), .busy(busy32),
    .cnt(cnt32), .done(done32), .fail(fail32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic b, input logic d, input logic r);
    exp_t e;
    e.cnt = c; e.busy = b; e.done = d; e.rdy = r;
    sbq.push_back(e);
  endtask

  // Idle / run / done expectations
  task automatic push_idle();
    push(8'd0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic push_run(input logic [7:0] c);
    push(c, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic push_done();
    push(8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=queue_empty expected=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, ".cnt"},  32'(cnt),       32'(e.cnt));
      chk({tag, ".busy"}, 32'(busy),      32'(e.busy));
      chk({tag, ".done"}, 32'(done),      32'(e.done));
      chk({tag, ".rdy"},  32'(start_rdy), 32'(e.rdy));
      chk({tag, ".fail"}, 32'(fail),      32'd0);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    sample(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start_vld = 1'b0; start_cnt = '0; pause = 1'b0; abort = 1'b0;
    start_vld32 = 1'b0; start_cnt32 = '0; pause32 = 1'b0; abort32 = 1'b0;
    #2;
    push_idle();
    sample("reset");
    chk("reset.cnt32", cnt32, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_idle();
    step("idle");

    // Width scaling on the 32-bit instance
    start_vld32 = 1'b1; start_cnt32 = 32'h0001_0000;
    @(posedge clk); #1;
    start_vld32 = 1'b0;
    chk("w32.load", cnt32, 32'h0001_0000);
    chk("w32.busy", 32'(busy32), 32'd1);
    @(posedge clk); #1;
    chk("w32.dec", cnt32, 32'h0000_FFFF);
    chk("w32.fail", 32'(fail32), 32'd0);
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    chk("w32.abort", cnt32, 32'd0);
    chk("w32.rdy", 32'(start_rdy32), 32'd1);

    // Basic N=5
    start_vld = 1'b1; start_cnt = 8'd5;
    push_run(8'd5);
    step("basic");
    start_vld = 1'b0;
    for (int c = 4; c >= 1; c--) begin
      push_run(8'(c));
      step("basic");
    end
    push_done();
    step("basic.done");
    push_idle();
    step("basic.idle");

    // Zero-length countdown
    start_vld = 1'b1; start_cnt = 8'd0;
    push_done();
    step("zero.done");
    start_vld = 1'b0;
    push_idle();
    step("zero.idle");

    // Pause for 3 cycles at cnt=7
    start_vld = 1'b1; start_cnt = 8'd10;
    push_run(8'd10);
    step("pause");
    start_vld = 1'b0;
    for (int c = 9; c >= 7; c--) begin
      push_run(8'(c));
      step("pause");
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_run(8'd7);
      step("pause.hold");
    end
    pause = 1'b0;
    for (int c = 6; c >= 1; c--) begin
      push_run(8'(c));
      step("pause");
    end
    push_done();
    step("pause.done");
    push_idle();
    step("pause.idle");

    // Abort (with pause) at cnt=4; start_vld during RUN ignored
    start_vld = 1'b1; start_cnt = 8'd10;
    push_run(8'd10);
    step("abort");
    start_cnt = 8'd99;
    for (int c = 9; c >= 4; c--) begin
      push_run(8'(c));
      step("abort.ignore_start");
    end
    start_vld = 1'b0;
    abort = 1'b1; pause = 1'b1;
    push_idle();
    step("abort.idle");
    abort = 1'b0; pause = 1'b0;
    push_idle();
    step("abort.no_done");

    // 0x80 -> 0x7F, then abort
    start_vld = 1'b1; start_cnt = 8'h80;
    push_run(8'h80);
    step("x80");
    start_vld = 1'b0;
    push_run(8'h7F);
    step("x80.dec");
    abort = 1'b1;
    push_idle();
    step("x80.abort");
    abort = 1'b0;

    // Full-range countdown from 0xFF
    start_vld = 1'b1; start_cnt = 8'hFF;
    push_run(8'hFF);
    step("xff");
    start_vld = 1'b0;
    for (int c = 254; c >= 1; c--) begin
      push_run(8'(c));
      step("xff");
    end
    push_done();
    step("xff.done");
    push_idle();
    step("xff.idle");

    // Asynchronous reset mid-RUN at cnt=3
    start_vld = 1'b1; start_cnt = 8'd5;
    push_run(8'd5);
    step("rst");
    start_vld = 1'b0;
    for (int c = 4; c >= 3; c--) begin
      push_run(8'(c));
      step("rst");
    end
    #2;
    rst_n = 1'b0;
    #1;
    push_idle();
    sample("rst.async");
    push_idle();
    step("rst.held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_idle();
      step("rst.no_done");
    end

    // Normal operation after reset
    start_vld = 1'b1; start_cnt = 8'd2;
    push_run(8'd2);
    step("post_rst");
    start_vld = 1'b0;
    push_run(8'd1);
    step("post_rst");
    push_done();
    step("post_rst.done");
    push_idle();
    step("post_rst.idle");

    chk("scoreboard.drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
